// File: rtl/tuning_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tuning_pkg
//  Description : Shared constants, step table and FSM state encoding for the
//                tuning controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package tuning_pkg;

    localparam int NUM_STEPS = 7;

    // Step index shown after reset (1 kHz)
    localparam logic [2:0] STEP_IDX_RST = 3'd3;
    localparam logic [2:0] STEP_IDX_MAX = 3'(NUM_STEPS - 1);

    // Step sizes in Hz, index 0 is the finest step
    localparam logic [NUM_STEPS-1:0][31:0] STEP_TABLE = {
        32'd1_000_000, 32'd100_000, 32'd10_000, 32'd1_000,
        32'd100, 32'd10, 32'd1
    };

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        IDLE  = 3'd1,
        MUL   = 3'd2,
        CLAMP = 3'd3,
        SEND  = 3'd4
    } tuning_state_t;

    // Advance a step index, wrapping from the last entry back to the first
    function automatic logic [2:0] step_wrap(input logic [2:0] idx);
        return (idx == STEP_IDX_MAX) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tuning_ctrl_fq_clamp.sv
`default_nettype none
// ============================================================================
//  Module      : fq_clamp
//  Description : Combinational saturating clamp of a signed FQ_WIDTH+2-bit
//                value into the unsigned band [F_MIN, F_MAX].
//  Revision    : 1.0 - initial release
// ============================================================================
module fq_clamp
    import tuning_pkg::*;
#(
    parameter int FQ_WIDTH = 32,
    parameter int F_MIN    = 100_000,
    parameter int F_MAX    = 30_000_000
) (
    input  logic signed [FQ_WIDTH+1:0] sum,
    output logic        [FQ_WIDTH-1:0] fq
);

    localparam logic signed [FQ_WIDTH+1:0] c_min = (FQ_WIDTH+2)'(F_MIN);
    localparam logic signed [FQ_WIDTH+1:0] c_max = (FQ_WIDTH+2)'(F_MAX);

    // Saturate below/above the band; the extra sign bits prevent any wrap
    always_comb begin
        if (sum < c_min) begin
            fq = FQ_WIDTH'(F_MIN);
        end else if (sum > c_max) begin
            fq = FQ_WIDTH'(F_MAX);
        end else begin
            fq = sum[FQ_WIDTH-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/tuning_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tuning_ctrl
//  Description : Dial/preset tuning controller. Scales signed dial deltas by
//                the selected step, accumulates and clamps the frequency word
//                and hands each new word to the NCO over valid/ready.
//                Optional macro TUNING_CTRL_ACCEL_EN: large deltas use the
//                next coarser step.
//  Revision    : 1.0 - initial release
// ============================================================================
module tuning_ctrl
    import tuning_pkg::*;
#(
    parameter int FQ_WIDTH     = 32,
    parameter int F_MIN        = 100_000,
    parameter int F_MAX        = 30_000_000,
    parameter int F_RESET      = 7_000_000,
    parameter int ACCEL_THRESH = 4
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [7:0]          fq_inc,
    input  logic                fq_inc_valid,
    input  logic                step_btn,
    input  logic                band_load,
    input  logic [FQ_WIDTH-1:0] band_fq,
    output logic [FQ_WIDTH-1:0] m_fq,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [2:0]          step_idx,
    output logic                busy
);

`ifdef TUNING_CTRL_ACCEL_EN
    localparam bit c_accel_en = 1'b1;
`else
    localparam bit c_accel_en = 1'b0;
`endif
    localparam logic [11:0] c_thresh = 12'(ACCEL_THRESH);

    tuning_state_t r_state, w_state_nxt;

    logic                       r_inc_valid_q;
    logic signed [11:0]         r_pend;
    logic                       r_pend_load;
    logic [FQ_WIDTH-1:0]        r_pend_fq;
    logic signed [11:0]         r_delta;
    logic [2:0]                 r_step_sel;
    logic [2:0]                 r_step_idx;
    logic                       r_is_load;
    logic [FQ_WIDTH-1:0]        r_load_fq;
    logic signed [FQ_WIDTH+1:0] r_prod;
    logic [FQ_WIDTH-1:0]        r_fq;

    logic                       w_edge;
    logic signed [12:0]         w_inc_ext;
    logic signed [12:0]         w_pend_sum;
    logic signed [11:0]         w_pend_sat;
    logic [11:0]                w_abs;
    logic [2:0]                 w_step_eff;
    logic                       w_load_req;
    logic [FQ_WIDTH-1:0]        w_load_val;
    logic                       w_dispatch;
    logic signed [FQ_WIDTH+1:0] w_sum;
    logic [FQ_WIDTH-1:0]        w_clamped;

    assign w_edge     = fq_inc_valid & ~r_inc_valid_q;
    assign w_inc_ext  = w_edge ? 13'(signed'(fq_inc)) : 13'sd0;
    assign w_pend_sum = 13'(r_pend) + w_inc_ext;
    // A load arriving this very cycle is newer than any latched one
    assign w_load_req = r_pend_load | band_load;
    assign w_load_val = band_load ? band_fq : r_pend_fq;
    // New work is taken in IDLE or on the cycle the NCO accepts a word
    assign w_dispatch = (r_state == IDLE) || ((r_state == SEND) && m_ready);

    // Saturating merge of pending and incoming delta, plus effective step
    always_comb begin
        w_pend_sat = w_pend_sum[11:0];
        if (w_pend_sum > 13'sd2047) begin
            w_pend_sat = 12'sd2047;
        end else if (w_pend_sum < -13'sd2047) begin
            w_pend_sat = -12'sd2047;
        end
        w_abs      = w_pend_sat[11] ? 12'(-w_pend_sat) : 12'(w_pend_sat);
        w_step_eff = r_step_idx;
        if (c_accel_en && (w_abs >= c_thresh) && (r_step_idx < STEP_IDX_MAX)) begin
            w_step_eff = r_step_idx + 3'd1;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            INIT:    w_state_nxt = SEND;
            MUL:     w_state_nxt = CLAMP;
            CLAMP:   w_state_nxt = SEND;
            IDLE, SEND: begin
                if (w_dispatch) begin
                    if (w_load_req) begin
                        w_state_nxt = CLAMP;
                    end else if (w_pend_sat != 12'sd0) begin
                        w_state_nxt = MUL;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = INIT;
        endcase
    end

    // State register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_sum = r_is_load ? signed'((FQ_WIDTH+2)'(r_load_fq))
                             : signed'((FQ_WIDTH+2)'(r_fq)) + r_prod;

    fq_clamp #(
        .FQ_WIDTH (FQ_WIDTH),
        .F_MIN    (F_MIN),
        .F_MAX    (F_MAX)
    ) u_fq_clamp (
        .sum (w_sum),
        .fq  (w_clamped)
    );

    // Datapath: edge capture, pending jobs, step index, product and word
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_inc_valid_q <= 1'b0;
            r_pend        <= '0;
            r_pend_load   <= 1'b0;
            r_pend_fq     <= '0;
            r_delta       <= '0;
            r_step_sel    <= STEP_IDX_RST;
            r_step_idx    <= STEP_IDX_RST;
            r_is_load     <= 1'b0;
            r_load_fq     <= '0;
            r_prod        <= '0;
            r_fq          <= FQ_WIDTH'(F_RESET);
        end else begin
            r_inc_valid_q <= fq_inc_valid;
            if (step_btn) begin
                r_step_idx <= step_wrap(r_step_idx);
            end
            if (w_dispatch) begin
                // A load discards any accumulated delta
                r_pend      <= '0;
                r_pend_load <= 1'b0;
                r_is_load   <= w_load_req;
                r_delta     <= w_pend_sat;
                r_step_sel  <= w_step_eff;
                if (w_load_req) begin
                    r_load_fq <= w_load_val;
                end
            end else begin
                r_pend <= w_pend_sat;
                if (band_load) begin
                    r_pend_load <= 1'b1;
                    r_pend_fq   <= band_fq;
                end
            end
            if (r_state == MUL) begin
                r_prod <= (FQ_WIDTH+2)'(r_delta) *
                          signed'((FQ_WIDTH+2)'(STEP_TABLE[r_step_sel]));
            end
            if (r_state == CLAMP) begin
                r_fq <= w_clamped;
            end
        end
    end

    assign m_fq     = r_fq;
    assign m_valid  = (r_state == SEND);
    assign busy     = (r_state != IDLE);
    assign step_idx = r_step_idx;

endmodule
`default_nettype wire
